subbytes_serial: RTL

Byte-serial AES SubBytes controller wrapped around the team's registered S-box LUT (`sboxaeslut`, 1-cycle latency). It accepts a 128-bit AES state over a valid/ready handshake and streams its 16 bytes, one per cycle, into the S-box. It collects the substituted bytes back into a 128-bit result and presents that result downstream over a second valid/ready handshake. The block sits between the round-state register and ShiftRows in the area-optimised AES datapath.

---
 rtl/subbytes_serial.sv | 95 +++++++++
 1 files changed

// File: rtl/subbytes_serial.sv
// subbytes_serial: byte-serial AES SubBytes around an external registered
// S-box. A 128-bit state is fed one byte per cycle (byte 0 first) into the
// S-box; results are shifted back into a collect register that becomes the
// output state. One state in flight at a time.
module subbytes_serial #(
  parameter int SBOX_LAT = 1               // S-box register latency, 1..4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [7:0]   sbox_in,
  input  logic [7:0]   sbox_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

  // DRAIN lasts SBOX_LAT cycles so the last byte fed has come back.
  localparam logic [3:0] DRAIN_LAST = 4'(SBOX_LAT - 1);

  state_t               state, state_nxt;
  logic [3:0]           cnt;
  logic [127:0]         feed;
  logic [127:0]         coll;
  logic [SBOX_LAT:1]    cap_pipe;
  logic                 feeding;
  logic                 cap_en;

  assign feeding   = (state == FEED);
  assign cap_en    = cap_pipe[SBOX_LAT];
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign sbox_in   = feeding ? feed[127:120] : 8'h00;
  assign out_data  = coll;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; in_valid/out_ready only matter in IDLE/DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (in_valid)           state_nxt = FEED;
      FEED:  if (cnt == 4'd15)       state_nxt = DRAIN;
      DRAIN: if (cnt == DRAIN_LAST)  state_nxt = DONE;
      DONE:  if (out_ready)          state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

  // Shared counter: byte index in FEED, wait count in DRAIN; cleared on
  // every state change so each phase starts from zero.
  always_ff @(posedge clk) begin
    if (rst)                                   cnt <= '0;
    else if (state != state_nxt)               cnt <= '0;
    else if (state == FEED || state == DRAIN)  cnt <= cnt + 4'd1;
  end

  // Feed register: load on accept, shift the next byte to the top in FEED.
  always_ff @(posedge clk) begin
    if (rst)                         feed <= '0;
    else if (in_ready && in_valid)   feed <= in_data;
    else if (feeding)                feed <= {feed[119:0], 8'h00};
  end

  // Capture enable: the FEED flag delayed to line up with S-box output.
  // Reset flushes it so an aborted run cannot capture stale bytes.
  generate
    if (SBOX_LAT == 1) begin : g_cap1
      always_ff @(posedge clk) begin
        if (rst) cap_pipe <= '0;
        else     cap_pipe <= feeding;
      end
    end else begin : g_capn
      always_ff @(posedge clk) begin
        if (rst) cap_pipe <= '0;
        else     cap_pipe <= {cap_pipe[SBOX_LAT-1:1], feeding};
      end
    end
  endgenerate

  // Collect register: shift in substituted bytes; byte 0 ends on top.
  always_ff @(posedge clk) begin
    if (rst)         coll <= '0;
    else if (cap_en) coll <= {coll[119:0], sbox_out};
  end

endmodule
